painel_scan_scheduler: RTL and testbench

- Sequences the LED-matrix column scan of the panel from the system clock.
- Combines three functions:
  - a programmable prescaler, which replaces fixed flip-flop chain division with a runtime-loadable divide value;
  - a column scan FSM with anti-ghosting blanking between columns;
  - a frame/scroll scheduler that advances the message offset.
- Sits between the clock source and the column drivers/message ROM addressing.

---
 rtl/painel_scan_scheduler_if.sv | 31 +++
 rtl/painel_scan_scheduler.sv | 177 +++++++++++++++++
 tb/tb_painel_scan_scheduler.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/painel_scan_scheduler_if.sv
// Control/status bundle between the panel controller and the column scan scheduler.
// The scheduler itself uses the slave modport.
interface painel_scan_scheduler_if #(
  parameter int NUM_COLS  = 5,
  parameter int COL_W     = 3,
  parameter int DIV_WIDTH = 16,
  parameter int OFS_W     = 6
);
  logic                 EN;
  logic                 DIV_LOAD;
  logic [DIV_WIDTH-1:0] DIV_VAL;
  logic [7:0]           SCROLL_PERIOD;
  logic                 STEP;
  logic [OFS_W-1:0]     MSG_LEN;
  logic                 TICK;
  logic [NUM_COLS-1:0]  COL_SEL;
  logic [COL_W-1:0]     COL_IDX;
  logic                 FRAME_DONE;
  logic [OFS_W-1:0]     SCROLL_OFS;
  logic                 BUSY;

  modport master (
    output EN, DIV_LOAD, DIV_VAL, SCROLL_PERIOD, STEP, MSG_LEN,
    input  TICK, COL_SEL, COL_IDX, FRAME_DONE, SCROLL_OFS, BUSY
  );

  modport slave (
    input  EN, DIV_LOAD, DIV_VAL, SCROLL_PERIOD, STEP, MSG_LEN,
    output TICK, COL_SEL, COL_IDX, FRAME_DONE, SCROLL_OFS, BUSY
  );
endinterface

// File: rtl/painel_scan_scheduler.sv
// LED-matrix column scan scheduler: loadable prescaler, scan/blank FSM and
// frame-based scroll offset generator.
module painel_scan_scheduler #(
  parameter int                   NUM_COLS    = 5,
  parameter int                   COL_W       = 3,
  parameter int                   DIV_WIDTH   = 16,
  parameter logic [DIV_WIDTH-1:0] DIV_DEFAULT = 16'd999,
  parameter int                   BLANK_CYC   = 2,
  parameter int                   OFS_W       = 6
) (
  input logic                    CLK,
  input logic                    RST_N,
  painel_scan_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } state_e;

  localparam int               BLK_W    = (BLANK_CYC > 2) ? $clog2(BLANK_CYC) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
  localparam logic [BLK_W-1:0] BLK_INIT = BLK_W'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [DIV_WIDTH-1:0] div_active_q, div_active_d;
  logic [DIV_WIDTH-1:0] div_shadow_q, div_shadow_d;
  logic [BLK_W-1:0]     blank_q, blank_d;
  logic [COL_W-1:0]     col_idx_q, col_idx_d;
  logic [NUM_COLS-1:0]  col_sel_q, col_sel_d;
  logic                 frame_done_q, frame_done_d;
  logic [7:0]           frame_cnt_q, frame_cnt_d;
  logic [OFS_W-1:0]     scroll_ofs_q, scroll_ofs_d;
  logic                 busy_q, busy_d;

  logic                 tick_s;
  logic                 frame_end_s;
  logic [COL_W-1:0]     col_next_s;
  logic [OFS_W:0]       ofs_inc_s;
  logic [OFS_W:0]       len_eff_s;
  logic [OFS_W-1:0]     ofs_next_s;

  assign tick_s      = (state_q == SCAN) && (pcnt_q == div_active_q);
  assign frame_end_s = tick_s && bus.EN && (col_idx_q == LAST_COL);
  assign col_next_s  = (col_idx_q == LAST_COL) ? '0 : (col_idx_q + COL_W'(1));
  assign ofs_inc_s   = {1'b0, scroll_ofs_q} + (OFS_W + 1)'(1);
  // A zero message length behaves as a single-column message.
  assign len_eff_s   = (bus.MSG_LEN == '0) ? (OFS_W + 1)'(1) : {1'b0, bus.MSG_LEN};
  assign ofs_next_s  = (ofs_inc_s >= len_eff_s) ? '0 : ofs_inc_s[OFS_W-1:0];

  // Next-state logic for the scan FSM, prescaler, scroll scheduler and output registers.
  always_comb begin
    state_d      = state_q;
    pcnt_d       = pcnt_q;
    div_active_d = div_active_q;
    div_shadow_d = bus.DIV_LOAD ? bus.DIV_VAL : div_shadow_q;
    blank_d      = blank_q;
    col_idx_d    = col_idx_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    scroll_ofs_d = scroll_ofs_q;

    case (state_q)
      IDLE: begin
        pcnt_d       = '0;
        col_idx_d    = '0;
        div_active_d = div_shadow_d;
        if (bus.EN) begin
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (!bus.EN) begin
          state_d     = IDLE;
          pcnt_d      = '0;
          col_idx_d   = '0;
          frame_cnt_d = '0;
        end else if (tick_s) begin
          pcnt_d       = '0;
          col_idx_d    = col_next_s;
          frame_done_d = (col_idx_q == LAST_COL);
          if (BLANK_CYC > 0) begin
            state_d = BLANK;
            blank_d = BLK_INIT;
          end else begin
            state_d      = SCAN;
            div_active_d = div_shadow_d;
          end
        end else begin
          pcnt_d = pcnt_q + DIV_WIDTH'(1);
        end
      end
      BLANK: begin
        if (!bus.EN) begin
          state_d     = IDLE;
          pcnt_d      = '0;
          col_idx_d   = '0;
          frame_cnt_d = '0;
        end else if (blank_q == '0) begin
          state_d      = SCAN;
          pcnt_d       = '0;
          div_active_d = div_shadow_d;
        end else begin
          blank_d = blank_q - BLK_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        pcnt_d    = '0;
        col_idx_d = '0;
      end
    endcase

    // Manual mode pins the frame counter; auto mode steps on completed frames only.
    if (bus.SCROLL_PERIOD == 8'd0) begin
      frame_cnt_d = '0;
      if (bus.STEP) begin
        scroll_ofs_d = ofs_next_s;
      end else begin
        scroll_ofs_d = scroll_ofs_q;
      end
    end else if (frame_end_s) begin
      if (frame_cnt_q >= (bus.SCROLL_PERIOD - 8'd1)) begin
        frame_cnt_d  = '0;
        scroll_ofs_d = ofs_next_s;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end else begin
      scroll_ofs_d = scroll_ofs_q;
    end

    col_sel_d = (state_d == SCAN) ? (NUM_COLS'(1) << col_idx_d) : '0;
    busy_d    = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      pcnt_q       <= '0;
      div_active_q <= DIV_DEFAULT;
      div_shadow_q <= DIV_DEFAULT;
      blank_q      <= '0;
      col_idx_q    <= '0;
      col_sel_q    <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      scroll_ofs_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      div_active_q <= div_active_d;
      div_shadow_q <= div_shadow_d;
      blank_q      <= blank_d;
      col_idx_q    <= col_idx_d;
      col_sel_q    <= col_sel_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      scroll_ofs_q <= scroll_ofs_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.TICK       = tick_s;
  assign bus.COL_SEL    = col_sel_q;
  assign bus.COL_IDX    = col_idx_q;
  assign bus.FRAME_DONE = frame_done_q;
  assign bus.SCROLL_OFS = scroll_ofs_q;
  assign bus.BUSY       = busy_q;

endmodule

// File: tb/tb_painel_scan_scheduler.sv
// Directed bench for painel_scan_scheduler: DIV=3, two blank cycles, five columns,
// so a column is 6 cycles and a frame 30 cycles.
module tb_painel_scan_scheduler;

  logic CLK = 1'b0;
  logic RST_N;
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  always #5 CLK = ~CLK;

  painel_scan_scheduler_if #(.NUM_COLS(5), .COL_W(3), .DIV_WIDTH(16), .OFS_W(6)) bus ();

  painel_scan_scheduler #(
    .NUM_COLS(5), .COL_W(3), .DIV_WIDTH(16), .DIV_DEFAULT(16'd999),
    .BLANK_CYC(2), .OFS_W(6)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_col_sel"},    32'(bus.COL_SEL),    32'd0);
    chk({pfx, "_col_idx"},    32'(bus.COL_IDX),    32'd0);
    chk({pfx, "_tick"},       32'(bus.TICK),       32'd0);
    chk({pfx, "_frame_done"}, 32'(bus.FRAME_DONE), 32'd0);
    chk({pfx, "_scroll_ofs"}, 32'(bus.SCROLL_OFS), 32'd0);
    chk({pfx, "_busy"},       32'(bus.BUSY),       32'd0);
  endtask

  // Expected outputs c cycles after SCAN entry, with DIV=3, BLANK=2, period 2, MSG_LEN 3.
  task automatic chk_run(input int c, input int ofs0);
    int pos;
    int col;
    int w;
    pos = c % 30;
    col = pos / 6;
    w   = pos % 6;
    chk("run_col_sel", 32'(bus.COL_SEL), (w < 4) ? (32'd1 << col) : 32'd0);
    chk("run_col_idx", 32'(bus.COL_IDX), (w < 4) ? 32'(col) : 32'((col + 1) % 5));
    chk("run_tick",    32'(bus.TICK),    (w == 3) ? 32'd1 : 32'd0);
    chk("run_fdone",   32'(bus.FRAME_DONE), (pos == 28) ? 32'd1 : 32'd0);
    chk("run_ofs",     32'(bus.SCROLL_OFS), 32'((ofs0 + ((c + 2) / 30) / 2) % 3));
    chk("run_busy",    32'(bus.BUSY),    32'd1);
    chk("run_onehot0", 32'($onehot0(bus.COL_SEL)), 32'd1);
  endtask

  task automatic pulse_step(input int exp_ofs);
    bus.STEP = 1'b1;
    @(negedge CLK);
    bus.STEP = 1'b0;
    chk("step_ofs", 32'(bus.SCROLL_OFS), 32'(exp_ofs));
  endtask

  int div_sel [17] = '{1, 1, 1, 0, 0, 2, 0, 0, 4, 0, 0, 8, 0, 0, 16, 0, 0};

  initial begin
    RST_N             = 1'b0;
    bus.EN            = 1'b0;
    bus.DIV_LOAD      = 1'b0;
    bus.DIV_VAL       = 16'd0;
    bus.SCROLL_PERIOD = 8'd2;
    bus.STEP          = 1'b0;
    bus.MSG_LEN       = 6'd3;

    repeat (2) @(negedge CLK);
    chk_zero("rst");
    RST_N = 1'b1;
    @(negedge CLK);
    chk("idle_busy",    32'(bus.BUSY),    32'd0);
    chk("idle_col_sel", 32'(bus.COL_SEL), 32'd0);

    bus.DIV_LOAD = 1'b1;
    bus.DIV_VAL  = 16'd3;
    @(negedge CLK);
    bus.DIV_LOAD = 1'b0;
    bus.DIV_VAL  = 16'd0;

    // Continuous scan long enough to see the offset wrap 0,1,2,0,1, ending mid column 3.
    bus.EN = 1'b1;
    for (int c = 0; c < 290; c++) begin
      @(negedge CLK);
      chk_run(c, 0);
    end

    // Abort during column 3 with the frame counter at 1.
    bus.EN = 1'b0;
    @(negedge CLK);
    chk("abort_col_sel", 32'(bus.COL_SEL),    32'd0);
    chk("abort_busy",    32'(bus.BUSY),       32'd0);
    chk("abort_col_idx", 32'(bus.COL_IDX),    32'd0);
    chk("abort_ofs",     32'(bus.SCROLL_OFS), 32'd1);
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      chk("off_fdone",   32'(bus.FRAME_DONE), 32'd0);
      chk("off_col_sel", 32'(bus.COL_SEL),    32'd0);
    end

    // Restart: column 0 again, offset kept, frame count restarted from 0.
    bus.EN = 1'b1;
    for (int c = 0; c <= 60; c++) begin
      @(negedge CLK);
      chk_run(c, 1);
    end

    // New divide value loaded mid-column: current column keeps 4 cycles, later ones 1.
    bus.DIV_LOAD = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(negedge CLK);
      bus.DIV_LOAD = 1'b0;
      chk("div_col_sel", 32'(bus.COL_SEL), 32'(div_sel[k]));
      chk("div_tick",    32'(bus.TICK),
          ((k == 2) || (k == 5) || (k == 8) || (k == 11) || (k == 14)) ? 32'd1 : 32'd0);
      chk("div_fdone",   32'(bus.FRAME_DONE), (k == 15) ? 32'd1 : 32'd0);
      chk("div_ofs",     32'(bus.SCROLL_OFS), 32'd2);
    end

    // Manual scroll with display off.
    bus.EN            = 1'b0;
    bus.SCROLL_PERIOD = 8'd0;
    bus.MSG_LEN       = 6'd0;
    @(negedge CLK);
    chk("man_busy", 32'(bus.BUSY),       32'd0);
    chk("man_ofs",  32'(bus.SCROLL_OFS), 32'd2);
    pulse_step(0);
    pulse_step(0);
    bus.MSG_LEN = 6'd4;
    pulse_step(1);
    pulse_step(2);
    pulse_step(3);
    pulse_step(0);
    pulse_step(1);
    @(negedge CLK);
    chk("man_hold_ofs", 32'(bus.SCROLL_OFS), 32'd1);

    // Asynchronous reset in the middle of a scan.
    bus.SCROLL_PERIOD = 8'd2;
    bus.DIV_LOAD      = 1'b1;
    bus.DIV_VAL       = 16'd3;
    @(negedge CLK);
    bus.DIV_LOAD = 1'b0;
    bus.EN       = 1'b1;
    repeat (8) @(negedge CLK);
    chk("pre_rst_col_sel", 32'(bus.COL_SEL), 32'd2);
    #2 RST_N = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge CLK);
    chk("rst_hold_col_sel", 32'(bus.COL_SEL), 32'd0);
    chk("rst_hold_busy",    32'(bus.BUSY),    32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rel_col_sel", 32'(bus.COL_SEL), 32'd1);
    chk("rel_col_idx", 32'(bus.COL_IDX), 32'd0);
    chk("rel_busy",    32'(bus.BUSY),    32'd1);
    chk("rel_tick",    32'(bus.TICK),    32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
